// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO frame scheduler.
// Holds the FSM state enum, default sizes and the rotate-priority pick.
package piso_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NREQ_DEF  = 2;
  localparam int MAX_NREQ  = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    DONE
  } state_e;

  // One-hot pick of the first set request, scanning upward
  // from (last+1) mod n and wrapping.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] req,
    input int                  n,
    input int                  last
  );
    logic [MAX_NREQ-1:0] g;
    logic                hit;
    int                  j;
    logic [4:0]          k;
    g   = '0;
    hit = 1'b0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i < n) begin
        j = last + 1 + i;
        if (j >= n) j = j - n;
        k = 5'(j);
        if (!hit && req[k]) begin
          g[k] = 1'b1;
          hit  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/piso_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index.
// Ports: req_i, last_i (previous winner) -> gnt_o, idx_o.
module piso_rr_arbiter
  import piso_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [MAX_NREQ-1:0] req_w;
  logic [MAX_NREQ-1:0] pick_w;
  logic                unused_pick;

  always_comb begin
    req_w             = '0;
    req_w[NREQ-1:0]   = req_i;
    pick_w            = rr_pick(req_w, NREQ, int'(last_i));
    gnt_o             = pick_w[NREQ-1:0];
    idx_o             = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_w[i]) idx_o = IDX_W'(i);
    end
  end

  assign unused_pick = ^pick_w;

endmodule

// File: rtl/piso_frame_scheduler.sv
// Shares one PISO shift stage among NREQ requesters, round-robin.
// Ports: clk, rst_n, req, data in; gnt, ser_out, ser_valid,
// frame_start, busy, done, owner out. Macro PISO_PARITY_EN adds
// an even-parity bit after each frame.
module piso_frame_scheduler
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      owner
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
`ifdef PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [NREQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [WIDTH-1:0]   word_w;
  logic               load_w;

  piso_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    word_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) word_w = data[i*WIDTH +: WIDTH];
    end
  end

  assign load_w = (state_q == IDLE) && (|arb_gnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_w) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, from registered state only (gnt also uses req)
  always_comb begin
    gnt         = '0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE: gnt = arb_gnt;
      SHIFT: begin
        ser_out     = shreg_q[WIDTH-1];
        ser_valid   = 1'b1;
        frame_start = (cnt_q == CNT_W'(WIDTH));
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        ser_out   = par_q;
        ser_valid = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign owner = owner_q;

  // Datapath next-state
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (load_w) begin
      shreg_d = word_w;
      cnt_d   = CNT_W'(WIDTH);
      owner_d = arb_idx;
      last_d  = arb_idx;
`ifdef PISO_PARITY_EN
      par_d   = ^word_w;
`endif
    end else if (state_q == SHIFT) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_frame_scheduler.sv
// Self-checking bench for piso_frame_scheduler (WIDTH=4, NREQ=2).
// Frames are scoreboarded and compared on each done pulse.
module tb_piso_frame_scheduler;

`ifdef PISO_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FL = 4 + NPAR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] data;
  logic [1:0] gnt;
  logic       ser_out, ser_valid, frame_start, busy, done;
  logic       owner;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         own;
    logic [3:0] word;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] req;
    logic [3:0] d0;
    logic [3:0] d1;
    int         nfr;
    int         own[4];
  } vec_t;
  vec_t vecs[5];

  piso_frame_scheduler #(.WIDTH(4), .NREQ(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data        (data),
    .gnt         (gnt),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_bits(input logic [3:0] w);
`ifdef PISO_PARITY_EN
    return {3'b000, w, ^w};
`else
    return {4'b0000, w};
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: got no done want done");
  endtask

  // Frame monitor: collects serial bits, checks against scoreboard
  logic [7:0] mbits;
  int         mn;
  always @(negedge clk) begin
    if (!rst_n) begin
      mbits = '0;
      mn    = 0;
    end else begin
      if (ser_valid) begin
        chk("frame_start_pos", int'(frame_start), int'(mn == 0));
        mbits = {mbits[6:0], ser_out};
        mn++;
      end else begin
        chk("ser_out_idle", int'(ser_out), 0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got frame %0h want none", mbits);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("frame_owner", int'(owner), e.own);
          chk("frame_bits", int'(mbits), int'(exp_bits(e.word)));
          chk("frame_len", mn, FL);
        end
        mbits = '0;
        mn    = 0;
      end
    end
  end

  initial begin
    logic [7:0] eb;
    exp_t       e;

    vecs[0] = '{req: 2'b11, d0: 4'hA, d1: 4'h5, nfr: 4, own: '{0, 1, 0, 1}};
    vecs[1] = '{req: 2'b01, d0: 4'hB, d1: 4'h0, nfr: 2, own: '{0, 0, 0, 0}};
    vecs[2] = '{req: 2'b10, d0: 4'h0, d1: 4'hC, nfr: 2, own: '{1, 1, 0, 0}};
    vecs[3] = '{req: 2'b01, d0: 4'h9, d1: 4'h0, nfr: 1, own: '{0, 0, 0, 0}};
    vecs[4] = '{req: 2'b11, d0: 4'h3, d1: 4'hE, nfr: 3, own: '{1, 0, 1, 0}};

    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_gnt", int'(gnt), 0);
      chk("idle_busy", int'(busy) + int'(ser_valid) + int'(done), 0);
      chk("idle_owner", int'(owner), 0);
    end

    // Single frame, timing and bit order
    @(negedge clk);
    req  = 2'b01;
    data = {4'h0, 4'b1011};
    e = '{own: 0, word: 4'b1011};
    sb.push_back(e);
    eb = exp_bits(4'b1011);
    #1;
    chk("sf_gnt", int'(gnt), 1);
    chk("sf_busy_grant", int'(busy), 0);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      chk("sf_valid", int'(ser_valid), 1);
      chk("sf_fs", int'(frame_start), int'(k == 0));
      chk("sf_bit", int'(ser_out), int'(eb[FL-1-k]));
      chk("sf_gnt_busy", int'(gnt), 0);
      if (k == 0) req = 2'b00;
    end
    @(negedge clk);
    chk("sf_done", int'(done), 1);
    chk("sf_done_busy", int'(busy), 1);
    chk("sf_done_valid", int'(ser_valid), 0);
    @(negedge clk);
    chk("sf_done_pulse", int'(done), 0);
    chk("sf_back_idle", int'(busy), 0);

    // Request raised mid-frame waits for IDLE
    req  = 2'b01;
    data = {4'h6, 4'hA};
    e = '{own: 0, word: 4'hA};
    sb.push_back(e);
    e = '{own: 1, word: 4'h6};
    sb.push_back(e);
    @(negedge clk);
    req = 2'b10;
    #1;
    chk("mf_gnt_shift", int'(gnt), 0);
    for (int k = 1; k < FL; k++) begin
      @(negedge clk);
      chk("mf_gnt_shift", int'(gnt), 0);
    end
    @(negedge clk);
    chk("mf_done", int'(done), 1);
    chk("mf_gnt_done", int'(gnt), 0);
    @(negedge clk);
    chk("mf_gnt_idle", int'(gnt), 2);
    @(negedge clk);
    req = 2'b00;
    wait_done();
    @(negedge clk);
    chk("mf_sb_drain", sb.size(), 0);

    // Table-driven frame sequences
    foreach (vecs[v]) begin
      for (int f = 0; f < vecs[v].nfr; f++) begin
        e.own  = vecs[v].own[f];
        e.word = (vecs[v].own[f] == 0) ? vecs[v].d0 : vecs[v].d1;
        sb.push_back(e);
      end
      req  = vecs[v].req;
      data = {vecs[v].d1, vecs[v].d0};
      for (int f = 0; f < vecs[v].nfr; f++) begin
        wait_done();
        if (f == vecs[v].nfr - 1) req = 2'b00;
      end
      @(negedge clk);
      chk("vec_sb_drain", sb.size(), 0);
      chk("vec_idle", int'(busy), 0);
    end

    // Reset during the second shift bit
    req  = 2'b01;
    data = {4'h0, 4'hF};
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(ser_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out", int'(ser_out) + int'(frame_start), 0);
    chk("rst_owner", int'(owner), 0);
    req  = 2'b10;
    data = {4'h9, 4'h0};
    e = '{own: 1, word: 4'h9};
    sb.push_back(e);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_gnt_r1", int'(gnt), 2);
    @(negedge clk);
    req = 2'b00;
    wait_done();
    @(negedge clk);
    chk("rst_sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
